// File: rtl/led_breather_pkg.sv
// Shared definitions for the LED breathing generator: ramp mode encodings,
// ramp direction type and elaboration-time helpers.
package led_breather_pkg;

  localparam logic MODE_TRIANGLE = 1'b0;
  localparam logic MODE_SAW      = 1'b1;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_t;

  // Staggered start level for channel c: (c * 2^w) / channels, truncated.
  function automatic int reset_duty(input int c, input int w, input int channels);
    longint num;
    num = longint'(c) << w;
    return int'(num / longint'(channels));
  endfunction

  // Width of the period divider: ceil(log2(div)), never less than one bit.
  function automatic int step_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/led_breather_if.sv
// Board-side bundle of the LED breathing generator.
// There is no valid/ready handshake here: run and mode are static levels
// sampled by the block (mode only on the duty-update cycle), led and
// period_tick are registered outputs, and dir_state exposes each channel's
// ramp direction (1 = up) so checkers can observe the ramp state.
interface led_breather_if #(
  parameter int CHANNELS = 5
);
  logic                run;
  logic                mode;
  logic [CHANNELS-1:0] led;
  logic                period_tick;
  logic [CHANNELS-1:0] dir_state;

  modport master (
    output run,
    output mode,
    input  led,
    input  period_tick,
    input  dir_state
  );

  modport slave (
    input  run,
    input  mode,
    output led,
    output period_tick,
    output dir_state
  );
endinterface

// File: rtl/led_pwm_channel.sv
// One breathing channel: holds its duty level and ramp direction, steps the
// ramp on the shared update strobe and compares the effective level against
// the shared PWM counter.
// Optional macro LED_BREATHER_GAMMA_EN: square-law brightness correction,
// registered at the strobe so LED latency is unchanged.
module led_pwm_channel
  import led_breather_pkg::*;
#(
  parameter int             W        = 11,
  parameter logic [W-1:0]   RST_DUTY = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pwm_cnt,
  input  logic         strobe,
  input  logic         mode,
  output logic         led,
  output logic         dir_up
);

  localparam logic [W-1:0] DUTY_MAX = '1;

  logic [W-1:0] duty;
  logic [W-1:0] duty_nxt;
  dir_t         dir;
  dir_t         dir_nxt;
  logic [W-1:0] eff;
  logic         led_nxt;

`ifdef LED_BREATHER_GAMMA_EN
  function automatic logic [W-1:0] gamma(input logic [W-1:0] d);
    logic [2*W-1:0] dx;
    dx = {{W{1'b0}}, d};
    return W'((dx * dx) >> W);
  endfunction

  localparam logic [W-1:0] RST_EFF = gamma(RST_DUTY);

  logic [W-1:0] eff_q;

  // Corrected level follows the new duty on the same edge the duty moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eff_q <= RST_EFF;
    end else if (strobe) begin
      eff_q <= gamma(duty_nxt);
    end
  end

  assign eff = eff_q;
`else
  assign eff = duty;
`endif

  // State register: duty level, ramp direction and the registered LED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty <= RST_DUTY;
      dir  <= UP;
      led  <= 1'b0;
    end else begin
      duty <= duty_nxt;
      dir  <= dir_nxt;
      led  <= led_nxt;
    end
  end

  // Next ramp state: only moves on the strobe; mode is looked at only then.
  always_comb begin
    duty_nxt = duty;
    dir_nxt  = dir;
    if (strobe) begin
      if (mode == MODE_SAW) begin
        duty_nxt = duty + 1'b1;
      end else if (dir == UP) begin
        if (duty == DUTY_MAX) begin
          duty_nxt = duty - 1'b1;
          dir_nxt  = DOWN;
        end else begin
          duty_nxt = duty + 1'b1;
        end
      end else begin
        if (duty == '0) begin
          duty_nxt = duty + 1'b1;
          dir_nxt  = UP;
        end else begin
          duty_nxt = duty - 1'b1;
        end
      end
    end
  end

  // Outputs: PWM compare (registered above) and direction for observation.
  always_comb begin
    led_nxt = (pwm_cnt < eff);
    dir_up  = (dir == UP);
  end

endmodule

// File: rtl/led_breather.sv
// Multi-channel LED breathing generator. Owns the free-running PWM counter,
// the period divider that produces the duty-update strobe, the period tick,
// and one led_pwm_channel per LED with phase-staggered start levels.
// Optional macro LED_BREATHER_GAMMA_EN enables square-law correction in the
// channels.
module led_breather
  import led_breather_pkg::*;
#(
  parameter int PWM_WIDTH = 11,
  parameter int CHANNELS  = 5,
  parameter int STEP_DIV  = 4
) (
  input  logic           clk,
  input  logic           rst,
  led_breather_if.slave  bus
);

  localparam int                STEP_W    = step_width(STEP_DIV);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [STEP_W-1:0]    step_cnt;
  logic                 wrap;
  logic                 strobe;
  logic                 period_tick_q;
  logic [CHANNELS-1:0]  led_w;
  logic [CHANNELS-1:0]  dir_w;

  // The strobe fires on the last clock of a period, so new duty levels take
  // effect exactly when pwm_cnt returns to zero.
  assign wrap   = (pwm_cnt == '1);
  assign strobe = wrap && bus.run && (step_cnt == STEP_LAST);

  // Free-running PWM counter and the tick that coincides with its zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt       <= '0;
      period_tick_q <= 1'b0;
    end else begin
      pwm_cnt       <= pwm_cnt + 1'b1;
      period_tick_q <= wrap;
    end
  end

  // Period divider: counts wraps while running, holds while stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (wrap && bus.run) begin
      if (step_cnt == STEP_LAST) begin
        step_cnt <= '0;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    led_pwm_channel #(
      .W        (PWM_WIDTH),
      .RST_DUTY (PWM_WIDTH'(reset_duty(c, PWM_WIDTH, CHANNELS)))
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .pwm_cnt (pwm_cnt),
      .strobe  (strobe),
      .mode    (bus.mode),
      .led     (led_w[c]),
      .dir_up  (dir_w[c])
    );
  end

  assign bus.led         = led_w;
  assign bus.period_tick = period_tick_q;
  assign bus.dir_state   = dir_w;

endmodule

// File: tb/tb_led_breather.sv
// Directed bench for led_breather with W=4, C=2. A second instance with
// STEP_DIV=3 runs alongside on the same clock and reset. Each PWM period is
// measured as the number of clocks each LED is high over 16 samples.
module tb_led_breather;

  logic clk;
  logic rst;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int p         = 0;

  led_breather_if #(.CHANNELS(2)) bus  ();
  led_breather_if #(.CHANNELS(2)) bus3 ();

  led_breather #(
    .PWM_WIDTH (4),
    .CHANNELS  (2),
    .STEP_DIV  (1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  led_breather #(
    .PWM_WIDTH (4),
    .CHANNELS  (2),
    .STEP_DIV  (3)
  ) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // High clocks per period for a given duty level.
  function automatic int exp_high(input int d);
`ifdef LED_BREATHER_GAMMA_EN
    return (d * d) >> 4;
`else
    return d;
`endif
  endfunction

  // Triangle sequence 0..15..0 with period 30 steps.
  function automatic int tri_wave(input int n);
    int t;
    t = n % 30;
    return (t <= 15) ? t : 30 - t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Measure one PWM period (16 samples at negedge); negative expectation skips.
  task automatic run_period(input int e0, input int e1, input int e3);
    int h0, h1, h3, t;
    h0 = 0; h1 = 0; h3 = 0; t = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      h0 += int'(bus.led[0]);
      h1 += int'(bus.led[1]);
      h3 += int'(bus3.led[0]);
      t  += int'(bus.period_tick);
    end
    check($sformatf("p%0d led0_high", p), h0, exp_high(e0));
    if (e1 >= 0) check($sformatf("p%0d led1_high", p), h1, exp_high(e1));
    if (e3 >= 0) check($sformatf("p%0d div3_led0_high", p), h3, exp_high(e3));
    check($sformatf("p%0d tick_count", p), t, 1);
    p++;
  endtask

  initial begin
    rst       = 1'b1;
    bus.run   = 1'b1;
    bus.mode  = 1'b0;
    bus3.run  = 1'b1;
    bus3.mode = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst led", bus.led, 2'b00);
    check("rst period_tick", bus.period_tick, 1'b0);
    check("rst dir_state", bus.dir_state, 2'b11);
    check("rst div3 led", bus3.led, 2'b00);
    rst = 1'b0;

    // Triangle ramp from release: led0 starts at 0, led1 at 8
    for (int k = 0; k < 35; k++) begin
      run_period(tri_wave(p), tri_wave(p + 8), p / 3);
    end

    // Run/stop: level 5 is in use now; freeze it for 10 periods
    bus.run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      run_period(5, -1, p / 3);
    end
    check("stop dir0", bus.dir_state[0], 1'b1);
    bus.run = 1'b1;
    run_period(5, -1, p / 3);
    run_period(6, -1, -1);
    for (int d = 7; d <= 13; d++) begin
      run_period(d, -1, -1);
    end

    // Sawtooth from 14: 14, 15, 0, 1
    bus.mode = 1'b1;
    run_period(14, -1, -1);
    run_period(15, -1, -1);
    run_period(0, -1, -1);
    bus.mode = 1'b0;
    check("saw dir0_held", bus.dir_state[0], 1'b1);
    run_period(1, -1, -1);
    run_period(2, -1, -1);

    // Asynchronous reset mid-period
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst led", bus.led, 2'b00);
    check("midrst period_tick", bus.period_tick, 1'b0);
    check("midrst dir_state", bus.dir_state, 2'b11);
    @(negedge clk);
    rst = 1'b0;
    p = 0;
    run_period(0, 8, 0);
    run_period(1, 9, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
